// File: rtl/axi_full_mst_burst_pkg.sv
// -----------------------------------------------------------------------------
// axi_full_mst_burst_pkg
// Shared definitions for the AXI4 burst initiator:
//   - AXI burst-type encoding used on AxBURST
//   - FSM state encoding (3-bit): IDLE / AW / W / B / AR / R
//   - axi_size(): AxSIZE value for a given data width in bits
// -----------------------------------------------------------------------------
package axi_full_mst_burst_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5
    } mst_state_t;

    // AxSIZE = log2(bytes per beat)
    function automatic logic [2:0] axi_size(input int dw);
        return 3'($clog2(dw / 8));
    endfunction

endpackage

// File: rtl/axi_full_mst_burst_beat_cnt.sv
// -----------------------------------------------------------------------------
// axi_full_mst_burst_beat_cnt
// 8-bit beat counter for one AXI burst.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : load 0 (new command accepted)
//   inc        : advance by one beat
//   len        : latched AxLEN (beats-1)
//   cnt        : current beat index
//   is_last    : cnt == len (current beat is the final one of the burst)
// -----------------------------------------------------------------------------
module axi_full_mst_burst_beat_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] len,
    output logic [7:0] cnt,
    output logic       is_last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign is_last = (cnt == len);

endmodule

// File: rtl/axi_full_mst_burst.sv
// -----------------------------------------------------------------------------
// axi_full_mst_burst
// AXI4 initiator: accepts one command at a time and issues it as a single
// INCR burst (write: AW -> W beats -> B, read: AR -> R beats).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_wr, cmd_addr, cmd_len
//   wd_valid/wd_ready          write data stream in (wd_data, wd_strb)
//   rd_valid/rd_ready          read data stream out (rd_data, rd_last)
//   done                       one-cycle pulse when B or the last R beat is taken
//   err                        sticky response error flag
//   mem_aw* / mem_w* / mem_b*  AXI4 write channels (master side)
//   mem_ar* / mem_r*           AXI4 read channels (master side)
//   dbg_state, dbg_cnt         FSM state and beat counter, for observation
//
// Handshake rule for every valid/ready pair here: a transfer happens on a
// rising clk edge where valid and ready are both 1; a raised valid is held
// with stable payload until that edge.
//
// Build option: define AXI_MST_RESP_CHK_EN to check BRESP/RRESP, BID/RID and
// RLAST placement and set err on any violation. Without it err is tied 0 and
// the response/ID inputs are ignored.
// -----------------------------------------------------------------------------
module axi_full_mst_burst
    import axi_full_mst_burst_pkg::*;
#(
    parameter int         DW     = 32,
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [31:0]       cmd_addr,
    input  logic [7:0]        cmd_len,
    // write data stream
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DW-1:0]     wd_data,
    input  logic [DW/8-1:0]   wd_strb,
    // read data stream
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DW-1:0]     rd_data,
    output logic              rd_last,
    // status
    output logic              done,
    output logic              err,
    // AXI write address
    output logic [3:0]        mem_awid,
    output logic [31:0]       mem_awaddr,
    output logic [7:0]        mem_awlen,
    output logic [2:0]        mem_awsize,
    output logic [1:0]        mem_awburst,
    output logic              mem_awvalid,
    input  logic              mem_awready,
    // AXI write data
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wstrb,
    output logic              mem_wlast,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    // AXI write response
    input  logic [3:0]        mem_bid,
    input  logic [1:0]        mem_bresp,
    input  logic              mem_bvalid,
    output logic              mem_bready,
    // AXI read address
    output logic [3:0]        mem_arid,
    output logic [31:0]       mem_araddr,
    output logic [7:0]        mem_arlen,
    output logic [2:0]        mem_arsize,
    output logic [1:0]        mem_arburst,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    // AXI read data
    input  logic [3:0]        mem_rid,
    input  logic [DW-1:0]     mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rlast,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    // observation
    output mst_state_t        dbg_state,
    output logic [7:0]        dbg_cnt
);

    localparam logic [2:0] AXSIZE = axi_size(DW);

    mst_state_t  state, state_nxt;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt;
    logic        is_last;

    logic cmd_fire, w_fire, b_fire, r_fire;

    assign cmd_fire = (state == ST_IDLE) && cmd_valid;
    assign w_fire   = (state == ST_W) && wd_valid && mem_wready;
    assign b_fire   = (state == ST_B) && mem_bvalid;
    assign r_fire   = (state == ST_R) && mem_rvalid && rd_ready;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid)   state_nxt = cmd_wr ? ST_AW : ST_AR;
            ST_AW:   if (mem_awready) state_nxt = ST_W;
            ST_W:    if (w_fire && is_last) state_nxt = ST_B;
            ST_B:    if (mem_bvalid)  state_nxt = ST_IDLE;
            ST_AR:   if (mem_arready) state_nxt = ST_R;
            // the slave's RLAST, not our counter, ends the read
            ST_R:    if (r_fire && mem_rlast) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        cmd_ready   = 1'b0;
        mem_awvalid = 1'b0;
        mem_arvalid = 1'b0;
        mem_wvalid  = 1'b0;
        wd_ready    = 1'b0;
        mem_wlast   = 1'b0;
        mem_bready  = 1'b0;
        rd_valid    = 1'b0;
        mem_rready  = 1'b0;
        rd_last     = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_AW:   mem_awvalid = 1'b1;
            ST_W: begin
                mem_wvalid = wd_valid;
                wd_ready   = mem_wready;
                mem_wlast  = is_last;
            end
            ST_B: begin
                mem_bready = 1'b1;
                done       = mem_bvalid;
            end
            ST_AR:   mem_arvalid = 1'b1;
            ST_R: begin
                rd_valid   = mem_rvalid;
                mem_rready = rd_ready;
                rd_last    = mem_rlast;
                done       = r_fire && mem_rlast;
            end
            default: ;
        endcase
    end

    // ---------------- command latch ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= 32'd0;
            len_q  <= 8'd0;
        end else if (cmd_fire) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
        end
    end

    // The counter stops at len so it ends each burst holding the final beat
    // index and never wraps, even for 256-beat bursts.
    axi_full_mst_burst_beat_cnt u_beat_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cmd_fire),
        .inc     ((w_fire || r_fire) && !is_last),
        .len     (len_q),
        .cnt     (cnt),
        .is_last (is_last)
    );

    assign mem_awid    = AXI_ID;
    assign mem_awaddr  = addr_q;
    assign mem_awlen   = len_q;
    assign mem_awsize  = AXSIZE;
    assign mem_awburst = AXI_BURST_INCR;
    assign mem_arid    = AXI_ID;
    assign mem_araddr  = addr_q;
    assign mem_arlen   = len_q;
    assign mem_arsize  = AXSIZE;
    assign mem_arburst = AXI_BURST_INCR;
    assign mem_wdata   = wd_data;
    assign mem_wstrb   = wd_strb;
    assign rd_data     = mem_rdata;
    assign dbg_state   = state;
    assign dbg_cnt     = cnt;

`ifdef AXI_MST_RESP_CHK_EN
    localparam logic [1:0] RESP_OKAY = 2'b00;

    logic err_q;
    logic err_hit;

    // Any bad response, wrong ID, or RLAST disagreeing with our beat count.
    assign err_hit = (b_fire && ((mem_bresp != RESP_OKAY) || (mem_bid != AXI_ID))) ||
                     (r_fire && ((mem_rresp != RESP_OKAY) || (mem_rid != AXI_ID) ||
                                 (mem_rlast != is_last)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_resp;
    logic unused_b_fire;
    assign unused_resp   = ^{mem_bid, mem_bresp, mem_rid, mem_rresp};
    assign unused_b_fire = b_fire;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_axi_full_mst_burst.sv
module tb_axi_full_mst_burst;
    import axi_full_mst_burst_pkg::*;

    localparam int DW        = 32;
    localparam int MEM_WORDS = 1024;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wd_valid = 1'b0, wd_ready;
    logic [31:0] wd_data = '0;
    logic [3:0]  wd_strb = '0;
    logic        rd_valid, rd_ready = 1'b0, rd_last;
    logic [31:0] rd_data;
    logic        done, err;
    logic [3:0]  mem_awid, mem_arid;
    logic [31:0] mem_awaddr, mem_araddr;
    logic [7:0]  mem_awlen, mem_arlen;
    logic [2:0]  mem_awsize, mem_arsize;
    logic [1:0]  mem_awburst, mem_arburst;
    logic        mem_awvalid, mem_awready = 1'b0;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wlast, mem_wvalid, mem_wready = 1'b0;
    logic [3:0]  mem_bid = '0;
    logic [1:0]  mem_bresp = '0;
    logic        mem_bvalid = 1'b0, mem_bready;
    logic        mem_arvalid, mem_arready = 1'b0;
    logic [3:0]  mem_rid = '0;
    logic [31:0] mem_rdata = '0;
    logic [1:0]  mem_rresp = '0;
    logic        mem_rlast = 1'b0, mem_rvalid = 1'b0, mem_rready;
    mst_state_t  dbg_state;
    logic [7:0]  dbg_cnt;

    axi_full_mst_burst #(.DW(DW), .AXI_ID(4'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .mem_awid(mem_awid), .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen),
        .mem_awsize(mem_awsize), .mem_awburst(mem_awburst),
        .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_bid(mem_bid), .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
        .mem_arid(mem_arid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
        .mem_arsize(mem_arsize), .mem_arburst(mem_arburst),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rid(mem_rid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference memory: what the memory must hold, from the commands alone.
    logic [31:0] ref_mem [0:MEM_WORDS-1];
    logic [31:0] slv_mem [0:MEM_WORDS-1];
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic int word_of(input logic [31:0] addr, input int beat);
        return (int'(addr[11:2]) + beat) % MEM_WORDS;
    endfunction

    // ---------------- bench slave (AXI memory) ----------------
    logic [31:0] aw_addr_s = '0, r_addr_s = '0;
    logic [7:0]  aw_len_s = '0, r_len_s = '0;
    int          w_idx = 0, r_idx = 0;
    bit          aw_seen = 0, b_pend = 0, r_act = 0, r_acc = 0;
    logic [1:0]  bresp_cfg = 2'b00;

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_awready = 0; mem_arready = 0; mem_wready = 0;
            mem_bvalid = 0; mem_rvalid = 0; mem_rlast = 0;
            aw_seen = 0; b_pend = 0; r_act = 0; r_idx = 0; w_idx = 0;
        end else begin
            mem_awready = ($urandom_range(0, 3) != 0);
            mem_arready = ($urandom_range(0, 3) != 0);
            mem_wready  = ($urandom_range(0, 3) != 0);
            mem_bvalid  = b_pend;
            mem_bresp   = b_pend ? bresp_cfg : 2'b00;
            if (!(mem_rvalid && !r_acc)) mem_rvalid = r_act && ($urandom_range(0, 3) != 0);
            mem_rdata = slv_mem[word_of(r_addr_s, r_idx)];
            mem_rlast = (r_idx == int'(r_len_s));
        end
        r_acc = 0;
        #1;
        if (rst_n) begin
            if (mem_awvalid && mem_awready) begin
                aw_addr_s = mem_awaddr; aw_len_s = mem_awlen; w_idx = 0; aw_seen = 1;
            end
            if (mem_wvalid) check("w_after_aw", aw_seen, 1'b1);
            if (mem_wvalid && mem_wready) begin
                check("wlast", mem_wlast, (w_idx == int'(aw_len_s)));
                slv_mem[word_of(aw_addr_s, w_idx)] =
                    apply_strb(slv_mem[word_of(aw_addr_s, w_idx)], mem_wdata, mem_wstrb);
                w_idx++;
                if (mem_wlast) begin b_pend = 1; aw_seen = 0; end
            end
            if (mem_bvalid && mem_bready) b_pend = 0;
            if (mem_arvalid && mem_arready) begin
                r_act = 1; r_addr_s = mem_araddr; r_len_s = mem_arlen; r_idx = 0;
            end
            if (mem_rvalid && mem_rready) begin
                r_acc = 1;
                if (r_idx == int'(r_len_s)) r_act = 0;
                else r_idx++;
            end
        end
    end

    // ---------------- write data source ----------------
    logic [35:0] wd_q[$];
    int wd_mode  = 0;   // 0: random gaps, 1: valid every other cycle
    int wd_beats = 0;
    bit wd_tog = 0, wd_acc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            wd_valid = 0;
        end else if (!(wd_valid && !wd_acc)) begin
            if (wd_mode == 1) begin
                wd_tog   = ~wd_tog;
                wd_valid = wd_tog && (wd_q.size() > 0);
            end else begin
                wd_valid = (wd_q.size() > 0) && ($urandom_range(0, 3) != 0);
            end
        end
        if (wd_q.size() > 0) {wd_strb, wd_data} = wd_q[0];
        wd_acc = 0;
        #1;
        if (rst_n && wd_valid && wd_ready) begin
            wd_acc = 1;
            if (wd_q.size() > 0) void'(wd_q.pop_front());
            wd_beats++;
        end
    end

    // ---------------- read data sink / done monitor ----------------
    int rd_mode  = 0;   // 0: random, 1: toggle
    int done_cnt = 0;
    bit rd_tog = 0;

    always @(negedge clk) begin
        if (rd_mode == 1) begin
            rd_tog   = ~rd_tog;
            rd_ready = rd_tog;
        end else begin
            rd_ready = ($urandom_range(0, 2) != 0);
        end
        #1;
        if (rst_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 1'b1, 1'b0);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
                check("rd_last", rd_last, exp_last_q.pop_front());
            end
        end
        if (done) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push_wbeat(input logic [31:0] addr, input int beat,
                              input logic [31:0] data, input logic [3:0] strb);
        ref_mem[word_of(addr, beat)] = apply_strb(ref_mem[word_of(addr, beat)], data, strb);
        wd_q.push_back({strb, data});
    endtask

    task automatic push_wburst(input logic [31:0] addr, input int len);
        for (int b = 0; b <= len; b++) push_wbeat(addr, b, $urandom, 4'($urandom_range(1, 15)));
    endtask

    task automatic expect_read(input logic [31:0] addr, input int len);
        for (int b = 0; b <= len; b++) begin
            exp_q.push_back(ref_mem[word_of(addr, b)]);
            exp_last_q.push_back(b == len);
        end
    endtask

    task automatic wait_done(input int start, input string tag);
        int cyc;
        cyc = 0;
        while (done_cnt == start && cyc < 5000) begin
            tick();
            cyc++;
        end
        check({tag, "_no_timeout"}, (cyc < 5000), 1'b1);
    endtask

    // One complete command: accept, address phase, data, completion.
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len);
        int start;
        start = done_cnt;
        @(negedge clk);
        cmd_valid = 1; cmd_wr = wr; cmd_addr = addr; cmd_len = len;
        #2;
        check("cmd_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 0;
        #2;
        check("axvalid", wr ? mem_awvalid : mem_arvalid, 1'b1);
        check("axvalid_other", wr ? mem_arvalid : mem_awvalid, 1'b0);
        check("axaddr", wr ? mem_awaddr : mem_araddr, addr);
        check("axlen", wr ? mem_awlen : mem_arlen, len);
        check("axsize", wr ? mem_awsize : mem_arsize, 3'd2);
        check("axburst", wr ? mem_awburst : mem_arburst, 2'b01);
        check("axid", wr ? mem_awid : mem_arid, 4'h0);
        check("cmd_ready_busy", cmd_ready, 1'b0);
        wait_done(start, "cmd");
        check("done_once", done_cnt - start, 1);
        check("cnt_end", dbg_cnt, len);
        tick();
        check("done_pulse_low", done, 1'b0);
        check("cmd_ready_again", cmd_ready, 1'b1);
        if (!wr) check("exp_drained", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, dbg_state, ST_IDLE);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check({tag, "_valids"}, {mem_awvalid, mem_wvalid, mem_arvalid, rd_valid, wd_ready}, 5'b0);
        check({tag, "_readies"}, {mem_bready, mem_rready}, 2'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_cnt"}, dbg_cnt, 8'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] orig, d1;
        int start, early, cyc, base, bad;

        for (int i = 0; i < MEM_WORDS; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end

        // reset state
        repeat (3) tick();
        check_idle_outputs("reset");
        check("reset_err", err, 1'b0);
        check("reset_awaddr", mem_awaddr, 32'h0);
        check("reset_awlen", mem_awlen, 8'h0);
        @(negedge clk); #3; rst_n = 1;
        tick();

        // single beat write then read back
        push_wbeat(32'h100, 0, 32'hDEADBEEF, 4'hF);
        run_cmd(1, 32'h100, 8'd0);
        check("mem_100", slv_mem[64], 32'hDEADBEEF);
        expect_read(32'h100, 0);
        run_cmd(0, 32'h100, 8'd0);

        // 4-beat write, valid every other cycle, partial strobe on beat 2
        wd_mode = 1;
        orig = ref_mem[129];
        d1   = 32'h1234_5678;
        push_wbeat(32'h200, 0, 32'hA0A0_0001, 4'hF);
        push_wbeat(32'h200, 1, d1, 4'h3);
        push_wbeat(32'h200, 2, 32'hA0A0_0003, 4'hF);
        push_wbeat(32'h200, 3, 32'hA0A0_0004, 4'hF);
        run_cmd(1, 32'h200, 8'd3);
        check("mem_200", slv_mem[128], 32'hA0A0_0001);
        check("mem_204_low_half", slv_mem[129], {orig[31:16], d1[15:0]});
        check("mem_20c", slv_mem[131], 32'hA0A0_0004);
        wd_mode = 0;

        // 8-beat read with toggling RD_READY
        rd_mode = 1;
        expect_read(32'h200, 7);
        run_cmd(0, 32'h200, 8'd7);
        rd_mode = 0;

        // command held high while busy: second one accepted once, after DONE
        push_wburst(32'h300, 3);
        expect_read(32'h300, 3);
        start = done_cnt;
        @(negedge clk);
        cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'h300; cmd_len = 8'd3;
        #2;
        check("hold_a_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_wr = 0;
        #2;
        early = 0; cyc = 0;
        while (done_cnt == start && cyc < 2000) begin
            if (cmd_ready) early++;
            tick();
            cyc++;
        end
        check("hold_a_no_timeout", (cyc < 2000), 1'b1);
        check("hold_early_ready", early, 0);
        check("hold_busy_at_done", cmd_ready, 1'b0);
        tick();
        check("hold_ready_after_done", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 0;
        #2;
        check("hold_b_arvalid", mem_arvalid, 1'b1);
        wait_done(start + 1, "hold_b");
        repeat (3) tick();
        check("hold_done_total", done_cnt - start, 2);
        check("hold_idle", dbg_state, ST_IDLE);
        check("hold_no_third", {mem_awvalid, mem_arvalid}, 2'b00);
        check("hold_exp_drained", exp_q.size(), 0);

        // asynchronous reset during beat 2 of an 8-beat write
        base = wd_beats;
        for (int b = 0; b < 8; b++) wd_q.push_back({4'hF, 32'($urandom)});
        @(negedge clk);
        cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'h400; cmd_len = 8'd7;
        #2;
        @(negedge clk);
        cmd_valid = 0;
        #2;
        cyc = 0;
        while ((wd_beats - base) < 1 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("rst_reached_beat2", (cyc < 500), 1'b1);
        #1;
        rst_n = 0;
        #1;
        check_idle_outputs("async_rst");
        wd_q.delete();
        @(posedge clk);
        #1;
        check("rst_edge_state", dbg_state, ST_IDLE);
        check("rst_edge_valids", {mem_awvalid, mem_wvalid, mem_arvalid, mem_bready}, 4'b0);
        check("rst_edge_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        @(negedge clk); #3; rst_n = 1;
        tick();
        push_wburst(32'h500, 2);
        run_cmd(1, 32'h500, 8'd2);
        expect_read(32'h500, 2);
        run_cmd(0, 32'h500, 8'd2);

        // randomized traffic
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            int          l;
            a       = 32'((384 + $urandom_range(0, 560)) * 4);
            l       = $urandom_range(0, 15);
            wd_mode = $urandom_range(0, 1);
            rd_mode = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                push_wburst(a, l);
                run_cmd(1, a, 8'(l));
            end else begin
                expect_read(a, l);
                run_cmd(0, a, 8'(l));
            end
        end
        wd_mode = 0; rd_mode = 0;

        // longest legal burst: 256 beats each way
        push_wburst(32'h800, 255);
        run_cmd(1, 32'h800, 8'd255);
        expect_read(32'h800, 255);
        run_cmd(0, 32'h800, 8'd255);

        check("err_clean", err, 1'b0);

        // slave error response
        bresp_cfg = 2'b10;
        push_wburst(32'h140, 1);
        run_cmd(1, 32'h140, 8'd1);
        bresp_cfg = 2'b00;
`ifdef AXI_MST_RESP_CHK_EN
        check("err_set", err, 1'b1);
`else
        check("err_tied", err, 1'b0);
`endif
        push_wburst(32'h150, 0);
        run_cmd(1, 32'h150, 8'd0);
`ifdef AXI_MST_RESP_CHK_EN
        check("err_sticky", err, 1'b1);
`else
        check("err_tied_after", err, 1'b0);
`endif

        // whole memory against the reference (reset-abandoned region excluded)
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++)
            if ((i < 256 || i > 263) && slv_mem[i] !== ref_mem[i]) bad++;
        check("mem_compare", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
